// File: rtl/apb_stream_fifo_slave.sv
// APB completer: APB writes fill a TX FIFO drained by a valid/ready stream; a stream fills an RX FIFO read over APB.
// Optional build macro APB_PROT_CHECK_EN: unprivileged (PPROT[0]=0) CTRL accesses are rejected with PSLVERR.
module apb_stream_fifo_slave #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    input  logic [3:0]        PSTRB,
    input  logic [2:0]        PPROT,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] PRDATA,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = 4;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [7:0] A_TXDATA = 8'h00;
    localparam logic [7:0] A_RXDATA = 8'h04;
    localparam logic [7:0] A_STATUS = 8'h08;
    localparam logic [7:0] A_CTRL   = 8'h0C;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state_q;
    logic [WW-1:0]       cnt_q, cnt_inc;
    logic                pready_q, err_q, err_d, sticky_q, sticky_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                setup_seen, wait_step, arm, done;
    logic                prot_bad;

    logic [DATA_W-1:0]   tx_mem [DEPTH];
    logic [DATA_W-1:0]   rx_mem [DEPTH];
    logic [AW-1:0]       tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [AW-1:0]       rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0]       tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic                m_valid_q, s_ready_q;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [DATA_W-1:0]   wmask, rx_head, status;
    logic                tx_push, tx_pop, rx_push, rx_pop, rx_wen;
    logic                ctrl_wr, flush_tx, flush_rx, clr_err;
    logic                unused_c;

    assign PREADY  = pready_q;
    assign PSLVERR = err_q;
    assign PRDATA  = rdata_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign s_ready = s_ready_q;
    assign unused_c = ^{PADDR[31:8], PPROT};

`ifdef APB_PROT_CHECK_EN
    assign prot_bad = !PPROT[0];
`else
    assign prot_bad = 1'b0;
`endif

    // arm: the coming edge raises PREADY, so response data/error are decided now
    assign setup_seen = (state_q == IDLE) && PSEL && !PENABLE;
    assign wait_step  = (state_q != IDLE) && PSEL && !pready_q;
    assign cnt_inc    = cnt_q + WW'(1);
    assign arm  = (setup_seen && (WAIT_STATES == 0)) || (wait_step && (cnt_inc == WW'(WAIT_STATES)));
    assign done = (state_q != IDLE) && PSEL && PENABLE && pready_q;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pready_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            pready_q <= arm;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            case (state_q)
                IDLE: begin
                    if (setup_seen) begin
                        state_q <= SETUP;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    if (!PSEL || pready_q) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= ACCESS;
                        cnt_q   <= cnt_inc;
                    end
                end
            endcase
        end
    end

    always_comb begin
        wmask = '0;
        for (int b = 0; b < 4; b++) begin
            if (PSTRB[b]) wmask[8*b +: 8] = PWDATA[8*b +: 8];
        end
    end

    // A completed transfer only has side effects if it was not answered with PSLVERR
    assign tx_push  = done && !err_q && (PADDR[7:0] == A_TXDATA);
    assign rx_pop   = done && !err_q && (PADDR[7:0] == A_RXDATA);
    assign ctrl_wr  = done && !err_q && (PADDR[7:0] == A_CTRL) && PSTRB[0];
    assign flush_tx = ctrl_wr && PWDATA[0];
    assign flush_rx = ctrl_wr && PWDATA[1];
    assign clr_err  = ctrl_wr && PWDATA[2];
    assign tx_pop   = m_valid_q && m_ready;
    assign rx_push  = s_valid && s_ready_q;
    assign rx_wen   = rx_push && !flush_rx;

    always_comb begin
        tx_wr_d  = tx_wr_q + AW'(tx_push);
        tx_rd_d  = tx_rd_q + AW'(tx_pop);
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        if (flush_tx) begin
            tx_rd_d  = tx_wr_q;
            tx_cnt_d = '0;
        end
        rx_wr_d  = rx_wr_q + AW'(rx_push);
        rx_rd_d  = rx_rd_q + AW'(rx_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        if (flush_rx) begin
            rx_wr_d  = rx_wr_q;
            rx_rd_d  = rx_wr_q;
            rx_cnt_d = '0;
        end
        m_data_d = (tx_push && (tx_wr_q == tx_rd_d)) ? wmask : tx_mem[tx_rd_d];
        sticky_d = sticky_q;
        if (done && err_q) sticky_d = 1'b1;
        if (clr_err)       sticky_d = 1'b0;
    end

    // Response uses the counts that will hold during the PREADY cycle
    assign rx_head = (rx_cnt_q == '0) ? s_data : rx_mem[rx_rd_q];
    assign status  = {11'd0, sticky_d, rx_cnt_d == '0, rx_cnt_d == FULL_CNT,
                      tx_cnt_d == '0, tx_cnt_d == FULL_CNT, 8'(rx_cnt_d), 8'(tx_cnt_d)};

    always_comb begin
        err_d   = 1'b0;
        rdata_d = '0;
        if (arm) begin
            case (PADDR[7:0])
                A_TXDATA: err_d = !PWRITE || (tx_cnt_d == FULL_CNT);
                A_RXDATA: begin
                    err_d = PWRITE || (rx_cnt_d == '0);
                    if (!err_d) rdata_d = rx_head;
                end
                A_STATUS: begin
                    err_d = PWRITE;
                    if (!PWRITE) rdata_d = status;
                end
                A_CTRL:   err_d = !PWRITE || prot_bad;
                default:  err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            tx_cnt_q  <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            rx_cnt_q  <= '0;
            sticky_q  <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_ready_q <= 1'b1;
        end else begin
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
            rx_cnt_q  <= rx_cnt_d;
            sticky_q  <= sticky_d;
            m_valid_q <= (tx_cnt_d != '0);
            m_data_q  <= m_data_d;
            s_ready_q <= (rx_cnt_d != FULL_CNT);
        end
    end

    always_ff @(posedge PCLK) begin
        if (tx_push) tx_mem[tx_wr_q] <= wmask;
        if (rx_wen)  rx_mem[rx_wr_q] <= s_data;
    end

endmodule

// File: tb/tb_apb_stream_fifo_slave.sv
// Directed self-checking bench for apb_stream_fifo_slave (DEPTH=8, WAIT_STATES=1).
module tb_apb_stream_fifo_slave;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned WS    = 1;
`ifdef APB_PROT_CHECK_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic [3:0]  PSTRB = '0;
    logic [2:0]  PPROT = '0;
    logic        PREADY, PSLVERR;
    logic [31:0] PRDATA;
    logic        m_valid, m_ready = 1'b0;
    logic [31:0] m_data;
    logic        s_valid = 1'b0, s_ready;
    logic [31:0] s_data = '0;

    int checks = 0;
    int errors = 0;
    bit stream_on_ready = 1'b0;

    logic [31:0] rd;
    logic        er;
    int          acc;

    apb_stream_fifo_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS), .DATA_W(32)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready)
    );

    always #5 PCLK = ~PCLK;

    // Called #1 after a rising edge; returns at the same phase after the completion edge
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot,
                            output logic [31:0] rdata, output logic err, output int n);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
        PWDATA = wdata; PSTRB = strb; PPROT = prot;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        n = 1;
        while (PREADY !== 1'b1 && n < 40) begin
            @(posedge PCLK); #1;
            n++;
        end
        rdata = PRDATA;
        err   = PSLVERR;
        if (PREADY !== 1'b1) begin
            checks++; errors++;
            $display("FAIL apb_timeout addr=%h: PREADY=%b after %0d cycles, required 1", addr, PREADY, n);
        end
        if (stream_on_ready) begin
            m_ready = 1'b1; s_valid = 1'b1; s_data = 32'h55;
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = '0;
        if (stream_on_ready) begin
            m_ready = 1'b0; s_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        checks++; if (PREADY !== 1'b0)   begin errors++; $display("FAIL rst_pready: got %b need 0", PREADY); end
        checks++; if (PSLVERR !== 1'b0)  begin errors++; $display("FAIL rst_pslverr: got %b need 0", PSLVERR); end
        checks++; if (PRDATA !== 32'h0)  begin errors++; $display("FAIL rst_prdata: got %h need 0", PRDATA); end
        checks++; if (m_valid !== 1'b0)  begin errors++; $display("FAIL rst_m_valid: got %b need 0", m_valid); end
        checks++; if (s_ready !== 1'b1)  begin errors++; $display("FAIL rst_s_ready: got %b need 1", s_ready); end
        PRESETn = 1'b1;
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, acc);
        checks++; if (rd !== 32'h000A0000) begin errors++; $display("FAIL rst_status: got %h need 000a0000", rd); end
        checks++; if (er !== 1'b0)         begin errors++; $display("FAIL rst_status_err: got %b need 0", er); end
        checks++; if (acc != 2)            begin errors++; $display("FAIL rst_latency: PREADY in access cycle %0d need 2", acc); end
    endtask

    task automatic test_tx_fill();
        for (int i = 0; i < 8; i++) begin
            apb_xfer(1'b1, 32'h00, 32'h11110000 + i, 4'hF, 3'b001, rd, er, acc);
            checks++; if (er !== 1'b0) begin errors++; $display("FAIL tx_push_err[%0d]: got %b need 0", i, er); end
        end
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, acc);
        checks++; if (rd !== 32'h00090008) begin errors++; $display("FAIL tx_full_status: got %h need 00090008", rd); end
        apb_xfer(1'b1, 32'h00, 32'h99999999, 4'hF, 3'b001, rd, er, acc);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL tx_overflow_err: got %b need 1", er); end
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, acc);
        checks++; if (rd !== 32'h00190008) begin errors++; $display("FAIL tx_sticky_status: got %h need 00190008", rd); end
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 32'h11110000 + i) begin
                errors++; $display("FAIL tx_drain[%0d]: got v=%b d=%h need v=1 d=%h", i, m_valid, m_data, 32'h11110000 + i);
            end
            @(posedge PCLK); #1;
        end
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL tx_drained_valid: got %b need 0", m_valid); end
        apb_xfer(1'b1, 32'h0C, 32'h4, 4'h1, 3'b001, rd, er, acc);
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, acc);
        checks++; if (rd !== 32'h000A0000) begin errors++; $display("FAIL clr_sticky_status: got %h need 000a0000", rd); end
    endtask

    task automatic test_rx_fill();
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = 32'hA0 + i;
            @(posedge PCLK); #1;
        end
        s_data = 32'hFF;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rx_full_ready: got %b need 0", s_ready); end
        @(posedge PCLK); #1;
        s_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            apb_xfer(1'b0, 32'h04, 32'h0, 4'h0, 3'b001, rd, er, acc);
            checks++;
            if (rd !== 32'hA0 + i || er !== 1'b0) begin
                errors++; $display("FAIL rx_read[%0d]: got d=%h e=%b need d=%h e=0", i, rd, er, 32'hA0 + i);
            end
        end
        apb_xfer(1'b0, 32'h04, 32'h0, 4'h0, 3'b001, rd, er, acc);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL rx_underflow: got d=%h e=%b need d=0 e=1", rd, er); end
        apb_xfer(1'b1, 32'h0C, 32'h4, 4'h1, 3'b001, rd, er, acc);
    endtask

    task automatic test_strobe();
        apb_xfer(1'b1, 32'h00, 32'hDEADBEEF, 4'b0101, 3'b001, rd, er, acc);
        checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL strobe_prdata_idle: got %h need 0", PRDATA); end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h00AD00EF) begin
            errors++; $display("FAIL strobe_data: got v=%b d=%h need v=1 d=00ad00ef", m_valid, m_data);
        end
        m_ready = 1'b1;
        @(posedge PCLK); #1;
        m_ready = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) apb_xfer(1'b1, 32'h00, 32'h200 + i, 4'hF, 3'b001, rd, er, acc);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 32'h300 + i;
            @(posedge PCLK); #1;
        end
        s_valid = 1'b0;
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, acc);
        checks++; if (rd !== 32'h00000404) begin errors++; $display("FAIL flush_pre_status: got %h need 00000404", rd); end
        stream_on_ready = 1'b1;
        apb_xfer(1'b1, 32'h0C, 32'h3, 4'h1, 3'b001, rd, er, acc);
        stream_on_ready = 1'b0;
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL flush_err: got %b need 0", er); end
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL flush_stream: got m_valid=%b s_ready=%b need 0/1", m_valid, s_ready);
        end
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, acc);
        checks++; if (rd !== 32'h000A0000) begin errors++; $display("FAIL flush_status: got %h need 000a0000", rd); end
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b001, rd, er, acc);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL unmapped_err: got %b need 1", er); end
        apb_xfer(1'b1, 32'h0C, 32'h4, 4'h1, 3'b001, rd, er, acc);
    endtask

    task automatic test_decode_errors();
        apb_xfer(1'b0, 32'h09, 32'h0, 4'h0, 3'b001, rd, er, acc);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL misaligned_err: got %b need 1", er); end
        apb_xfer(1'b0, 32'h0C, 32'h0, 4'h0, 3'b001, rd, er, acc);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL ctrl_read: got d=%h e=%b need d=0 e=1", rd, er); end
        apb_xfer(1'b1, 32'h08, 32'h0, 4'hF, 3'b001, rd, er, acc);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL status_write_err: got %b need 1", er); end
        apb_xfer(1'b1, 32'h04, 32'h0, 4'hF, 3'b001, rd, er, acc);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL rxdata_write_err: got %b need 1", er); end
        apb_xfer(1'b1, 32'h00, 32'h77, 4'hF, 3'b001, rd, er, acc);
        apb_xfer(1'b1, 32'h0C, 32'h1, 4'h0, 3'b001, rd, er, acc);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL ctrl_nostrb_err: got %b need 0", er); end
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, acc);
        checks++; if (rd !== 32'h00180001) begin errors++; $display("FAIL ctrl_nostrb_status: got %h need 00180001", rd); end
        apb_xfer(1'b1, 32'h0C, 32'h5, 4'h1, 3'b001, rd, er, acc);
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, acc);
        checks++; if (rd !== 32'h000A0000) begin errors++; $display("FAIL ctrl_flush_clr: got %h need 000a0000", rd); end
    endtask

    task automatic test_prot();
        apb_xfer(1'b1, 32'h00, 32'h1, 4'hF, 3'b001, rd, er, acc);
        apb_xfer(1'b1, 32'h00, 32'h2, 4'hF, 3'b001, rd, er, acc);
        apb_xfer(1'b1, 32'h0C, 32'h1, 4'h1, 3'b000, rd, er, acc);
        checks++; if (er !== PROT_EN) begin errors++; $display("FAIL prot_user_err: got %b need %b", er, PROT_EN); end
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b000, rd, er, acc);
        checks++;
        if (rd !== (PROT_EN ? 32'h00180002 : 32'h000A0000)) begin
            errors++; $display("FAIL prot_user_status: got %h need %h", rd, PROT_EN ? 32'h00180002 : 32'h000A0000);
        end
        apb_xfer(1'b1, 32'h0C, 32'h5, 4'h1, 3'b001, rd, er, acc);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL prot_priv_err: got %b need 0", er); end
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, acc);
        checks++; if (rd !== 32'h000A0000) begin errors++; $display("FAIL prot_priv_status: got %h need 000a0000", rd); end
    endtask

    task automatic test_back_to_back();
        apb_xfer(1'b1, 32'h00, 32'hCAFE, 4'hF, 3'b001, rd, er, acc);
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, acc);
        checks++; if (rd !== 32'h00080001) begin errors++; $display("FAIL b2b_status: got %h need 00080001", rd); end
        checks++; if (acc != 2) begin errors++; $display("FAIL b2b_latency: got %0d need 2", acc); end
        checks++; if (m_data !== 32'hCAFE) begin errors++; $display("FAIL b2b_mdata: got %h need 0000cafe", m_data); end
        m_ready = 1'b1;
        @(posedge PCLK); #1;
        m_ready = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, acc);
        checks++; if (rd !== 32'h000A0000 || acc != 2) begin errors++; $display("FAIL idle_read: got %h/%0d need 000a0000/2", rd, acc); end
    endtask

    task automatic test_reset_mid();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h00; PWDATA = 32'hBAD; PSTRB = 4'hF; PPROT = 3'b001;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PRESETn = 1'b0;
        @(posedge PCLK); #1;
        checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL mid_rst_pready: got %b need 0", PREADY); end
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = '0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_no_push: got m_valid=%b need 0", m_valid); end
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, acc);
        checks++; if (rd !== 32'h000A0000) begin errors++; $display("FAIL mid_rst_status: got %h need 000a0000", rd); end
    endtask

    initial begin
        test_reset();
        test_tx_fill();
        test_rx_fill();
        test_strobe();
        test_flush();
        test_decode_errors();
        test_prot();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
